seq_alu: RTL and testbench

//  Parametrised multi-cycle ALU, next generation of the datapath ALU. Registers all results,

---
 rtl/seq_alu.sv | 217 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with registered results, HI/LO state and iterative MUL/DIV.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, op, sign launch request, 4-bit opcode, signed/unsigned select
//   cmp             compare condition for CMP
//   a, b            operands
//   busy            high while a MUL/DIV is in flight (including the FIX cycle)
//   done            one-cycle pulse when y/hi/lo/flags are updated
//   y, hi, lo       main result and HI/LO registers
//   flags           {C,Z,N,V}
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             sign,
    input  logic [2:0]       cmp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [3:0]       flags
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

    stateT            state, stateNext;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] accHi, accLo;   // MUL: partial product; DIV: remainder/quotient
    logic [WIDTH-1:0] opMag;          // MUL: |a| addend; DIV: |b| divisor
    logic [WIDTH-1:0] opA;            // raw dividend for divide-by-zero / overflow results
    logic             isMul, negLo, negHi, divZero, divOvf;

    // Single-cycle result and flag computation
    logic [WIDTH-1:0] resY;
    logic [3:0]       resFlags;
    logic [WIDTH:0]   ext;
    logic             flagUpd, cOut, vOut, lt, eq, cmpR;
    logic [SHW-1:0]   shAmt;

    always_comb begin
        resY     = y;
        resFlags = flags;
        ext      = '0;
        flagUpd  = 1'b0;
        cOut     = 1'b0;
        vOut     = 1'b0;
        cmpR     = 1'b0;
        shAmt    = a[SHW-1:0];
        eq       = (a == b);
        lt       = sign ? ($signed(a) < $signed(b)) : (a < b);
        case (op)
            4'b0000: resY = b;
            4'b0001: begin
                ext     = {1'b0, a} + {1'b0, b};
                resY    = ext[WIDTH-1:0];
                cOut    = ext[WIDTH];
                vOut    = sign & (a[WIDTH-1] == b[WIDTH-1]) & (resY[WIDTH-1] != a[WIDTH-1]);
                flagUpd = 1'b1;
            end
            4'b0010: begin
                resY    = a - b;
                cOut    = (a < b);
                vOut    = sign & (a[WIDTH-1] != b[WIDTH-1]) & (resY[WIDTH-1] != a[WIDTH-1]);
                flagUpd = 1'b1;
            end
            4'b0101: resY = a & b;
            4'b0110: resY = a | b;
            4'b0111: resY = ~(a | b);
            4'b1000: resY = a ^ b;
            4'b1001: resY = b >> shAmt;
            4'b1010: resY = b << shAmt;
            4'b1011: resY = WIDTH'($signed(b) >>> shAmt);
            4'b1100: resY = {a[HALF-1:0], {HALF{1'b0}}};
            4'b1101: begin
                ext     = {1'b0, b} + (WIDTH+1)'(4);
                resY    = ext[WIDTH-1:0];
                cOut    = ext[WIDTH];
                vOut    = sign & ~b[WIDTH-1] & resY[WIDTH-1];
                flagUpd = 1'b1;
            end
            4'b1110: begin
                case (cmp)
                    3'b000:  cmpR = eq;
                    3'b001:  cmpR = ~eq;
                    3'b010:  cmpR = lt;
                    3'b011:  cmpR = lt | eq;
                    3'b100:  cmpR = ~(lt | eq);
                    3'b101:  cmpR = ~lt;
                    default: cmpR = 1'b0;
                endcase
                resY = {{(WIDTH-1){1'b0}}, cmpR};
            end
            default: resY = y;   // MUL/DIV never write y; reserved holds y
        endcase
        if (flagUpd) begin
            resFlags = {cOut, (resY == '0), resY[WIDTH-1], vOut};
        end
    end

    // Iteration step for shift-add multiply and restoring divide
    logic [WIDTH:0]   mulSum, divShift, divDiff;
    logic [WIDTH-1:0] magA, magB;
    logic [2*WIDTH-1:0] prod, prodFix;
    logic [WIDTH-1:0] quoFix, remFix;

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opMag} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divDiff  = divShift - {1'b0, opMag};
        magA     = (sign && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
        magB     = (sign && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
        prod     = {accHi, accLo};
        prodFix  = negLo ? ((2*WIDTH)'(0) - prod) : prod;
        quoFix   = negLo ? (WIDTH'(0) - accLo) : accLo;
        remFix   = negHi ? (WIDTH'(0) - accHi) : accHi;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) begin
                if (op == OP_MUL)      stateNext = MUL;
                else if (op == OP_DIV) stateNext = DIV;
            end
            MUL, DIV: if (cnt == SHW'(WIDTH-1)) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            y <= '0; hi <= '0; lo <= '0; flags <= '0;
            busy <= 1'b0; done <= 1'b0; cnt <= '0;
            accHi <= '0; accLo <= '0; opMag <= '0; opA <= '0;
            isMul <= 1'b0; negLo <= 1'b0; negHi <= 1'b0; divZero <= 1'b0; divOvf <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (stateNext != IDLE);
            case (state)
                IDLE: if (start) begin
                    cnt     <= '0;
                    accHi   <= '0;
                    opA     <= a;
                    isMul   <= (op == OP_MUL);
                    divZero <= (b == '0);
                    divOvf  <= sign && (a == MIN_VAL) && (b == '1);
                    negHi   <= sign & a[WIDTH-1];
                    negLo   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                    if (op == OP_MUL) begin
                        opMag <= magA;
                        accLo <= magB;
                    end else if (op == OP_DIV) begin
                        opMag <= magB;
                        accLo <= magA;
                    end else begin
                        y     <= resY;
                        flags <= resFlags;
                        done  <= 1'b1;
                    end
                end
                MUL: begin
                    accHi <= mulSum[WIDTH:1];
                    accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                    cnt   <= cnt + SHW'(1);
                end
                DIV: begin
                    if (!divDiff[WIDTH]) begin
                        accHi <= divDiff[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], 1'b1};
                    end else begin
                        accHi <= divShift[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + SHW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (isMul) begin
                        {hi, lo} <= prodFix;
                    end else if (divZero) begin
                        lo    <= '1;
                        hi    <= opA;
                        flags <= {flags[3:1], 1'b1};
                    end else if (divOvf) begin
                        lo    <= opA;
                        hi    <= '0;
                        flags <= {flags[3:1], 1'b1};
                    end else begin
                        lo <= quoFix;
                        hi <= remFix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu with hand-computed expectations.
module tb_seq_alu;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset, start, sign;
    logic [3:0]       op;
    logic [2:0]       cmp;
    logic [WIDTH-1:0] a, b;
    logic             busy, done;
    logic [WIDTH-1:0] y, hi, lo;
    logic [3:0]       flags;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign), .cmp(cmp),
        .a(a), .b(b), .busy(busy), .done(done), .y(y), .hi(hi), .lo(lo), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one start pulse; returns #1 after the edge that samples it.
    task automatic issue(input logic [3:0] o, input logic s, input logic [2:0] c,
                         input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        op = o; sign = s; cmp = c; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic runSingle(input string tag, input logic [3:0] o, input logic s,
                             input logic [2:0] c, input logic [31:0] aa, input logic [31:0] bb,
                             input logic [31:0] expY, input logic [3:0] expFl);
        issue(o, s, c, aa, bb);
        checkEq({tag, "_y"}, y, expY);
        checkEq({tag, "_flags"}, 32'(flags), 32'(expFl));
        checkEq({tag, "_done"}, 32'(done), 32'd1);
    endtask

    // Launches MUL/DIV; done is expected WIDTH+1 edges after the sampling edge,
    // i.e. seen by the next stage on the WIDTH+2nd edge counting the start edge.
    task automatic runMulti(input string tag, input logic [3:0] o, input logic s,
                            input logic [31:0] aa, input logic [31:0] bb,
                            input logic [31:0] expHi, input logic [31:0] expLo,
                            input logic [31:0] expY, input logic [3:0] expFl);
        int edges;
        int busyCycles;
        issue(o, s, 3'b000, aa, bb);
        a = 32'h5A5A5A5A; b = 32'hA5A5A5A5; op = 4'b0001;  // ignored while busy
        edges = 0;
        busyCycles = busy ? 1 : 0;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busyCycles++;
        end
        checkEq({tag, "_latency"}, 32'(edges), 32'(WIDTH + 1));
        checkEq({tag, "_busyCycles"}, 32'(busyCycles), 32'(WIDTH + 1));
        checkEq({tag, "_hi"}, hi, expHi);
        checkEq({tag, "_lo"}, lo, expLo);
        checkEq({tag, "_y"}, y, expY);
        checkEq({tag, "_flags"}, 32'(flags), 32'(expFl));
        @(posedge clk);
        #1;
        checkEq({tag, "_donePulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dones;
        reset = 1'b1; start = 1'b0; op = '0; sign = 1'b0; cmp = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst_y", y, 32'd0);
        checkEq("rst_hilo", hi | lo, 32'd0);
        checkEq("rst_flags", 32'(flags), 32'd0);
        checkEq("rst_busyDone", 32'({busy, done}), 32'd0);
        reset = 1'b0;

        // Single-cycle ops: flags tracked by hand from op to op
        runSingle("addOvf", 4'b0001, 1'b1, 3'b000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0011);
        @(posedge clk);
        #1;
        checkEq("single_donePulse", 32'(done), 32'd0);
        runSingle("subBorrow", 4'b0010, 1'b0, 3'b000, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1010);
        runSingle("cmpLtU", 4'b1110, 1'b0, 3'b010, 32'd3, 32'd5, 32'd1, 4'b1010);
        runSingle("cmpLtS", 4'b1110, 1'b1, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b1010);
        runSingle("cmpLtU2", 4'b1110, 1'b0, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1010);
        runSingle("cmpGeS", 4'b1110, 1'b1, 3'b101, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1010);
        runSingle("cmpGtU", 4'b1110, 1'b0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b1010);
        runSingle("cmpLeEq", 4'b1110, 1'b0, 3'b011, 32'd7, 32'd7, 32'd1, 4'b1010);
        runSingle("cmpNe", 4'b1110, 1'b0, 3'b001, 32'd7, 32'd7, 32'd0, 4'b1010);
        runSingle("cmpRsvd", 4'b1110, 1'b0, 3'b110, 32'd7, 32'd7, 32'd0, 4'b1010);
        runSingle("passb", 4'b0000, 1'b0, 3'b000, 32'd0, 32'h1234, 32'h1234, 4'b1010);
        runSingle("and", 4'b0101, 1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1010);
        runSingle("or", 4'b0110, 1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 4'b1010);
        runSingle("nor", 4'b0111, 1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 4'b1010);
        runSingle("xor", 4'b1000, 1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b1010);
        runSingle("srl", 4'b1001, 1'b0, 3'b000, 32'd4, 32'h80000000, 32'h08000000, 4'b1010);
        runSingle("sllWrapAmt", 4'b1010, 1'b0, 3'b000, 32'h21, 32'h1, 32'h2, 4'b1010);
        runSingle("sra", 4'b1011, 1'b0, 3'b000, 32'd4, 32'h80000000, 32'hF8000000, 4'b1010);
        runSingle("lui", 4'b1100, 1'b0, 3'b000, 32'h1234ABCD, 32'd0, 32'hABCD0000, 4'b1010);
        runSingle("add4Carry", 4'b1101, 1'b0, 3'b000, 32'd0, 32'hFFFFFFFC, 32'd0, 4'b1100);
        runSingle("subOvfS", 4'b0010, 1'b1, 3'b000, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0001);
        runSingle("reserved", 4'b1111, 1'b0, 3'b000, 32'd9, 32'd9, 32'h7FFFFFFF, 4'b0001);
        runSingle("add4Ovf", 4'b1101, 1'b1, 3'b000, 32'd0, 32'h7FFFFFFC, 32'h80000000, 4'b0011);

        // Iterative ops: y and flags must hold unless divide-by-zero/overflow sets V
        runMulti("mulS", 4'b0011, 1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h80000000, 4'b0011);
        runMulti("mulU", 4'b0011, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h80000000, 4'b0011);
        runMulti("divS", 4'b0100, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 4'b0011);
        runMulti("divU", 4'b0100, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 32'h80000000, 4'b0011);
        runSingle("addClr", 4'b0001, 1'b0, 3'b000, 32'd1, 32'd1, 32'd2, 4'b0000);
        runMulti("divZero", 4'b0100, 1'b0, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 32'd2, 4'b0001);
        runSingle("addClr2", 4'b0001, 1'b0, 3'b000, 32'd1, 32'd1, 32'd2, 4'b0000);
        runMulti("divOvf", 4'b0100, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd2, 4'b0001);

        // start while busy must be ignored: exactly one done, y untouched
        issue(4'b0011, 1'b0, 3'b000, 32'd2, 32'd3);
        repeat (3) @(posedge clk);
        issue(4'b0001, 1'b0, 3'b000, 32'd1, 32'd1);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checkEq("busyStart_dones", 32'(dones), 32'd1);
        checkEq("busyStart_y", y, 32'd2);
        checkEq("busyStart_lo", lo, 32'd6);

        // Reset during a MUL aborts it: hi/lo cleared, no done afterwards
        issue(4'b0011, 1'b0, 3'b000, 32'd5, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkEq("abort_busy", 32'(busy), 32'd0);
        checkEq("abort_hilo", hi | lo, 32'd0);
        checkEq("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checkEq("abort_noDone", 32'(dones), 32'd0);
        runSingle("afterAbort", 4'b0001, 1'b0, 3'b000, 32'd1, 32'd2, 32'd3, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
